// File: rtl/sequenciador_ula.sv
// ============================================================================
// sequenciador_ula : issues requests to the combinational 8-bit ULA, adds a
// multi-cycle multiply (repeated ULA adds) and a zero-test. Rev 1.0
// ============================================================================
`default_nettype none

module sequenciador_ula #(
  parameter int LARGURA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [LARGURA-1:0] req_a,
  input  logic [LARGURA-1:0] req_b,
  output logic [LARGURA-1:0] ula_dado1,
  output logic [LARGURA-1:0] ula_dado2,
  output logic [1:0]         ula_op,
  input  logic [LARGURA-1:0] ula_resultado,
  input  logic               ula_notzero,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [LARGURA-1:0] resp_resultado,
  output logic               resp_zero
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_SLT   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_TESTZ = 3'b100;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_SLT = 2'b10;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXEC   = 2'd1,
    MULT   = 2'd2,
    RESP   = 2'd3
  } estado_t;

  estado_t            state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [LARGURA-1:0] a_q, a_d;
  logic [LARGURA-1:0] b_q, b_d;
  logic [LARGURA-1:0] acc_q, acc_d;
  logic [LARGURA-1:0] cnt_q, cnt_d;
  logic [LARGURA-1:0] result_q, result_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= OCIOSO;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_resultado = '0;
    ula_dado1      = '0;
    ula_dado2      = '0;
    ula_op         = ULA_ADD;

    case (state_q)
      OCIOSO: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d     = req_op;
          a_d      = req_a;
          b_d      = req_b;
          acc_d    = '0;
          cnt_d    = req_b;
          result_d = '0;
          case (req_op)
            OP_ADD, OP_SUB, OP_SLT, OP_TESTZ: state_d = EXEC;
            OP_MUL:  state_d = (req_b == '0) ? RESP : MULT;
            default: state_d = RESP;
          endcase
        end
      end
      EXEC: begin
        ula_dado1 = a_q;
        ula_dado2 = b_q;
        case (op_q)
          OP_SUB:  ula_op = ULA_SUB;
          OP_SLT:  ula_op = ULA_SLT;
          default: ula_op = ULA_ADD;
        endcase
        if (op_q == OP_TESTZ) begin
          result_d = {{(LARGURA-1){1'b0}}, ula_notzero};
        end else begin
          result_d = ula_resultado;
        end
        state_d = RESP;
      end
      MULT: begin
        // acc accumulates a once per remaining count of b
        ula_dado1 = acc_q;
        ula_dado2 = a_q;
        ula_op    = ULA_ADD;
        acc_d     = ula_resultado;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == {{(LARGURA-1){1'b0}}, 1'b1}) begin
          result_d = ula_resultado;
          state_d  = RESP;
        end
      end
      RESP: begin
        resp_valid     = 1'b1;
        resp_resultado = result_q;
        if (resp_ready) begin
          state_d = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase

    // Outputs read as idle for the whole reset cycle, even mid-operation.
    if (reset) begin
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_resultado = '0;
      ula_dado1      = '0;
      ula_dado2      = '0;
      ula_op         = ULA_ADD;
    end
  end

  assign resp_zero = (resp_resultado == '0);

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_ula.sv
// ============================================================================
// tb_sequenciador_ula : randomized and directed bench for sequenciador_ula,
// with an ULA model and a behavioural result/latency reference. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sequenciador_ula;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'b000;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic [7:0] ula_dado1, ula_dado2, ula_resultado;
  logic [1:0] ula_op;
  logic       ula_notzero;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_resultado;
  logic       resp_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  sequenciador_ula #(.LARGURA(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .ula_dado1(ula_dado1), .ula_dado2(ula_dado2), .ula_op(ula_op),
    .ula_resultado(ula_resultado), .ula_notzero(ula_notzero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_resultado(resp_resultado), .resp_zero(resp_zero)
  );

  // Combinational ULA the block is meant to drive.
  always_comb begin
    case (ula_op)
      2'b00:   ula_resultado = ula_dado1 + ula_dado2;
      2'b01:   ula_resultado = ula_dado1 - ula_dado2;
      2'b10:   ula_resultado = ($signed(ula_dado1) < $signed(ula_dado2)) ? 8'h01 : 8'h00;
      default: ula_resultado = 8'h00;
    endcase
    ula_notzero = (ula_dado1 != 8'h00);
  end

  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int p;
    case (op)
      3'd0: p = int'($signed(a)) + int'($signed(b));
      3'd1: p = int'($signed(a)) - int'($signed(b));
      3'd2: p = ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: p = int'($signed(a)) * int'(b);
      3'd4: p = (a != 8'h00) ? 1 : 0;
      default: p = 0;
    endcase
    return p[7:0];
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [7:0] b);
    if (op == 3'd3) return int'(b);
    if (op <= 3'd4) return 1;
    return 0;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int lat;
    int guard;
    logic [7:0] exp;
    exp = ref_result(op, a, b);
    @(negedge clock);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_req op=%0d: req_ready=%b required 1", op, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_op = 3'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 300) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    vectors++;
    if (lat != ref_latency(op, b)) begin
      miscompares++;
      $display("FAIL latency op=%0d a=%h b=%h: got %0d edges required %0d", op, a, b, lat, ref_latency(op, b));
    end
    vectors++;
    if (resp_resultado !== exp) begin
      miscompares++;
      $display("FAIL result op=%0d a=%h b=%h: got %h required %h", op, a, b, resp_resultado, exp);
    end
    vectors++;
    if (resp_zero !== (exp == 8'h00)) begin
      miscompares++;
      $display("FAIL zero op=%0d a=%h b=%h: got %b required %b", op, a, b, resp_zero, exp == 8'h00);
    end
    vectors++;
    if (ula_dado1 !== 8'h00 || ula_dado2 !== 8'h00 || ula_op !== 2'b00) begin
      miscompares++;
      $display("FAIL ula_idle op=%0d: dado1=%h dado2=%h op=%b required 00 00 00", op, ula_dado1, ula_dado2, ula_op);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL after_handshake op=%0d: resp_valid=%b req_ready=%b required 0 1", op, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_resultado !== 8'h00 || resp_zero !== 1'b1 ||
        ula_dado1 !== 8'h00 || ula_dado2 !== 8'h00 || ula_op !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b vld=%b res=%h z=%b d1=%h d2=%h op=%b required 0 0 00 1 00 00 00",
               req_ready, resp_valid, resp_resultado, resp_zero, ula_dado1, ula_dado2, ula_op);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: req_ready=%b resp_valid=%b required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_directed();
    do_op(3'd0, 8'h7F, 8'h01);
    do_op(3'd1, 8'h05, 8'h05);
    do_op(3'd2, 8'hFE, 8'h01);
    do_op(3'd2, 8'h01, 8'hFE);
    do_op(3'd3, 8'hFD, 8'h04);
    do_op(3'd3, 8'h10, 8'h10);
    do_op(3'd3, 8'h55, 8'h00);
    do_op(3'd3, 8'h81, 8'hFF);
    do_op(3'd4, 8'h00, 8'h33);
    do_op(3'd4, 8'h80, 8'h00);
    do_op(3'd7, 8'h12, 8'h34);
    do_op(3'd5, 8'hFF, 8'hFF);
  endtask

  task automatic test_back_to_back();
    // Request held valid through EXEC and RESP must wait for the handshake.
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd0; req_a = 8'h03; req_b = 8'h04;
    @(posedge clock);
    @(negedge clock);
    req_op = 3'd1; req_a = 8'h09; req_b = 8'h02;
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_resultado !== 8'h07 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure cyc=%0d: vld=%b res=%h rdy=%b required 1 07 0", i, resp_valid, resp_resultado, req_ready);
      end
      @(posedge clock);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL held_req_ready: req_ready=%b resp_valid=%b required 1 0", req_ready, resp_valid);
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (resp_valid !== 1'b1 || resp_resultado !== ref_result(3'd1, 8'h09, 8'h02)) begin
      miscompares++;
      $display("FAIL held_req_result: vld=%b res=%h required 1 %h", resp_valid, resp_resultado, ref_result(3'd1, 8'h09, 8'h02));
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clock);
    req_valid = 1'b1; req_op = 3'd3; req_a = 8'h05; req_b = 8'd100;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0 || ula_dado2 !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_in_reset: vld=%b rdy=%b d2=%h required 0 0 00", resp_valid, req_ready, ula_dado2);
    end
    reset = 1'b0;
    seen = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
    end
    resp_ready = 1'b0;
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_idle: response or not-ready seen after reset, required idle");
    end
    do_op(3'd0, 8'h10, 8'h20);
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] a, b;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      do_op(op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
